// File: rtl/array_frame_master_if.sv
// Shared types and the handshake bundle for array_frame_master.
// Every port is a sync/notify pair: a transfer happens on a rising clk edge
// where both the sync and the notify signal of that port are 1.

package array_frame_master_pkg;
    typedef logic signed [31:0] int32_t;
    typedef int32_t [4:0] int_5;
endpackage

interface array_frame_master_if;
    import array_frame_master_pkg::*;

    int32_t      elem_in;
    logic        elem_in_sync;
    logic        elem_in_notify;

    int_5        arr_out;
    logic        arr_out_sync;
    logic        arr_out_notify;

    int32_t      res_in;
    logic        res_in_sync;
    logic        res_in_notify;

    int32_t      res_out;
    logic        res_out_sync;
    logic        res_out_notify;

    logic [7:0]  frame_cnt;

    // The block's own view of the bundle.
    modport master (
        input  elem_in, elem_in_sync, arr_out_sync, res_in, res_in_sync, res_out_sync,
        output elem_in_notify, arr_out, arr_out_notify, res_in_notify,
               res_out, res_out_notify, frame_cnt
    );

    // The peer's view: producer of elements, frame consumer, result source and sink.
    modport slave (
        output elem_in, elem_in_sync, arr_out_sync, res_in, res_in_sync, res_out_sync,
        input  elem_in_notify, arr_out, arr_out_notify, res_in_notify,
               res_out, res_out_notify, frame_cnt
    );
endinterface

// File: rtl/array_frame_master.sv
// Collects five scalar elements into a frame, hands the frame to a peer,
// waits for the peer's result and forwards it to a consumer. Each completed
// round trip increments an 8-bit counter. All outputs come straight from
// registers, so no input reaches an output within a cycle.

module array_frame_master
    import array_frame_master_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    array_frame_master_if.master bus
);

    typedef enum logic [1:0] {
        COLLECT,
        SEND,
        WAIT_RESP,
        FORWARD
    } state_t;

    state_t      r_state;
    logic [2:0]  r_idx;
    int_5        r_frame;
    int_5        r_arr_out;
    int32_t      r_res_reg;
    logic [7:0]  r_frame_cnt;
    logic        r_elem_in_notify;
    logic        r_arr_out_notify;
    logic        r_res_in_notify;
    logic        r_res_out_notify;

    int_5        w_frame_next;

    // Frame contents including the element arriving this cycle, so the fifth
    // element can go straight into arr_out on the edge that completes the frame.
    always_comb begin
        // NOTE: assign a full default first so every path writes the whole
        // variable; a partially written always_comb target infers a latch.
        w_frame_next          = r_frame;
        w_frame_next[r_idx]   = bus.elem_in;
    end

    // Handshake FSM: advances on transfers of the port owned by the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= COLLECT;
            r_idx            <= 3'd0;
            // NOTE: the frame bank is reset along with the control state so a
            // partial frame can never leak into a frame sent after reset.
            r_frame          <= '0;
            r_arr_out        <= '0;
            r_res_reg        <= '0;
            r_frame_cnt      <= 8'd0;
            r_elem_in_notify <= 1'b1;
            r_arr_out_notify <= 1'b0;
            r_res_in_notify  <= 1'b0;
            r_res_out_notify <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (r_state)
                COLLECT: begin
                    if (bus.elem_in_sync && r_elem_in_notify) begin
                        r_frame <= w_frame_next;
                        if (r_idx == 3'd4) begin
                            r_idx            <= 3'd0;
                            r_arr_out        <= w_frame_next;
                            r_elem_in_notify <= 1'b0;
                            r_arr_out_notify <= 1'b1;
                            r_state          <= SEND;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                SEND: begin
                    if (bus.arr_out_sync && r_arr_out_notify) begin
                        r_arr_out_notify <= 1'b0;
                        r_res_in_notify  <= 1'b1;
                        r_state          <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.res_in_sync && r_res_in_notify) begin
                        r_res_reg        <= bus.res_in;
                        r_res_in_notify  <= 1'b0;
                        r_res_out_notify <= 1'b1;
                        r_state          <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (bus.res_out_sync && r_res_out_notify) begin
                        r_frame_cnt      <= r_frame_cnt + 8'd1;
                        r_idx            <= 3'd0;
                        r_res_out_notify <= 1'b0;
                        r_elem_in_notify <= 1'b1;
                        r_state          <= COLLECT;
                    end
                end
                default: begin
                    r_state          <= COLLECT;
                    r_idx            <= 3'd0;
                    r_elem_in_notify <= 1'b1;
                    r_arr_out_notify <= 1'b0;
                    r_res_in_notify  <= 1'b0;
                    r_res_out_notify <= 1'b0;
                end
            endcase
        end
    end

    assign bus.elem_in_notify = r_elem_in_notify;
    assign bus.arr_out        = r_arr_out;
    assign bus.arr_out_notify = r_arr_out_notify;
    assign bus.res_in_notify  = r_res_in_notify;
    assign bus.res_out        = r_res_reg;
    assign bus.res_out_notify = r_res_out_notify;
    assign bus.frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_array_frame_master.sv
// Bench for array_frame_master: a transaction-level model (element queue plus
// pending-frame / pending-result flags) is compared with the DUT on every
// falling edge, and directed scenarios add hand-computed literal checks.

module tb_array_frame_master;
    import array_frame_master_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    array_frame_master_if bus ();

    array_frame_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];
    int m_arr[5];
    int m_res;
    int m_cnt;
    bit m_have_frame;
    bit m_await_res;
    bit m_have_res;

    function automatic logic [3:0] m_notify();
        return {!(m_have_frame || m_await_res || m_have_res),
                m_have_frame, m_await_res, m_have_res};
    endfunction

    // Model update: one accepted transfer per edge, on the port currently owed service.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                for (int i = 0; i < 5; i++) m_arr[i] = 0;
                m_res        = 0;
                m_cnt        = 0;
                m_have_frame = 0;
                m_await_res  = 0;
                m_have_res   = 0;
            end else begin
                logic [3:0] n;
                n = m_notify();
                if (n[3] && bus.elem_in_sync) begin
                    m_q.push_back(bus.elem_in);
                    if (m_q.size() == 5) begin
                        for (int i = 0; i < 5; i++) m_arr[i] = m_q[i];
                        m_q.delete();
                        m_have_frame = 1;
                    end
                end else if (n[2] && bus.arr_out_sync) begin
                    m_have_frame = 0;
                    m_await_res  = 1;
                end else if (n[1] && bus.res_in_sync) begin
                    m_res       = bus.res_in;
                    m_await_res = 0;
                    m_have_res  = 1;
                end else if (n[0] && bus.res_out_sync) begin
                    m_have_res = 0;
                    m_cnt      = (m_cnt + 1) % 256;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        @(posedge rst);
        forever begin
            @(negedge clk);
            check("notify", {28'd0, bus.elem_in_notify, bus.arr_out_notify,
                             bus.res_in_notify, bus.res_out_notify}, {28'd0, m_notify()});
            for (int i = 0; i < 5; i++)
                check($sformatf("arr_out[%0d]", i), bus.arr_out[i], m_arr[i]);
            check("res_out", bus.res_out, m_res);
            check("frame_cnt", {24'd0, bus.frame_cnt}, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_notify(input int which);
        case (which)
            0:       return bus.elem_in_notify;
            1:       return bus.arr_out_notify;
            2:       return bus.res_in_notify;
            default: return bus.res_out_notify;
        endcase
    endfunction

    task automatic wait_notify(input int which, input string name);
        int n = 0;
        while (!sel_notify(which) && n < 50) begin
            tick();
            n++;
        end
        check({name, " wait"}, {31'd0, sel_notify(which)}, 32'd1);
    endtask

    task automatic push_elem(input int v);
        wait_notify(0, "elem_in_notify");
        bus.elem_in      = v;
        bus.elem_in_sync = 1'b1;
        tick();
        bus.elem_in_sync = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            1:       bus.arr_out_sync = 1'b1;
            2:       bus.res_in_sync  = 1'b1;
            default: bus.res_out_sync = 1'b1;
        endcase
        tick();
        bus.arr_out_sync = 1'b0;
        bus.res_in_sync  = 1'b0;
        bus.res_out_sync = 1'b0;
    endtask

    task automatic full_txn(input int base, input int res);
        for (int i = 0; i < 5; i++) push_elem(base + i);
        wait_notify(1, "arr_out_notify");
        pulse(1);
        wait_notify(2, "res_in_notify");
        bus.res_in = res;
        pulse(2);
        wait_notify(3, "res_out_notify");
        pulse(3);
    endtask

    task automatic check_frame(input string name, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
        int exp[5];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++)
            check($sformatf("%s[%0d]", name, i), bus.arr_out[i], exp[i]);
    endtask

    function automatic logic [31:0] notifies();
        return {28'd0, bus.elem_in_notify, bus.arr_out_notify,
                bus.res_in_notify, bus.res_out_notify};
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        rst              = 1'b0;
        bus.elem_in      = 0;
        bus.elem_in_sync = 1'b0;
        bus.arr_out_sync = 1'b0;
        bus.res_in       = 0;
        bus.res_in_sync  = 1'b0;
        bus.res_out_sync = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset notifies", notifies(), 32'h8);
        check("reset frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        check("reset res_out", bus.res_out, 32'd0);
        tick();

        // Full transaction, back-to-back elements
        push_elem(10); push_elem(20); push_elem(30); push_elem(40); push_elem(50);
        check("send notifies", notifies(), 32'h4);
        check_frame("first frame", 10, 20, 30, 40, 50);

        // Output backpressure
        repeat (4) begin
            tick();
            check("stalled arr_out_notify", {31'd0, bus.arr_out_notify}, 32'd1);
            check("stalled arr_out[4]", bus.arr_out[4], 32'd50);
        end
        pulse(1);
        check("wait_resp notifies", notifies(), 32'h2);
        check("retained arr_out[2]", bus.arr_out[2], 32'd30);

        // Result path
        bus.res_in = -7;
        pulse(2);
        check("forward notifies", notifies(), 32'h1);
        check("res_out -7", bus.res_out, 32'hFFFF_FFF9);
        pulse(3);
        check("after forward notifies", notifies(), 32'h8);
        check("frame_cnt 1", {24'd0, bus.frame_cnt}, 32'd1);
        check("retained res_out", bus.res_out, 32'hFFFF_FFF9);

        // Gapped input with stray result-port syncs during COLLECT
        bus.res_in_sync  = 1'b1;
        bus.res_out_sync = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.elem_in      = (i % 2 == 0) ? (i / 2 + 1) : 99;
            bus.elem_in_sync = (i % 2 == 0);
            tick();
        end
        bus.elem_in_sync = 1'b0;
        bus.res_in_sync  = 1'b0;
        bus.res_out_sync = 1'b0;
        check("gapped notifies", notifies(), 32'h4);
        check_frame("gapped frame", 1, 2, 3, 4, 5);
        check("stray syncs frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
        pulse(1);
        bus.res_in = 123;
        pulse(2);
        check("res_out 123", bus.res_out, 32'd123);
        pulse(3);
        check("frame_cnt 2", {24'd0, bus.frame_cnt}, 32'd2);

        // Reset mid-frame
        push_elem(7); push_elem(8); push_elem(9);
        rst = 1'b1;
        #2;
        check("midreset notifies", notifies(), 32'h8);
        check("midreset frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        check("midreset arr_out[0]", bus.arr_out[0], 32'd0);
        tick();
        tick();
        rst = 1'b0;
        push_elem(100); push_elem(101); push_elem(102); push_elem(103); push_elem(104);
        check_frame("post-reset frame", 100, 101, 102, 103, 104);
        pulse(1);
        bus.res_in = 5;
        pulse(2);
        pulse(3);
        check("post-reset frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);

        // Counter wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 256; t++) begin
            full_txn(t * 5, t - 3);
            if (t == 254)
                check("frame_cnt 255", {24'd0, bus.frame_cnt}, 32'd255);
        end
        check("frame_cnt wrap", {24'd0, bus.frame_cnt}, 32'd0);
        check("wrap last res_out", bus.res_out, 32'd252);
        check("wrap notifies", notifies(), 32'h8);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
